bounce_frame_sequencer: RTL and testbench

//  Top-level game sequencer for color bounce. Divides clk into frame ticks and runs each frame as

---
 rtl/bounce_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_bounce_frame_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_frame_sequencer.sv
// bounce_frame_sequencer
//   Top-level game sequencer for color bounce. Divides clk into frame ticks
//   and runs every frame as erase -> update -> check -> draw, strobing the
//   game updater through statesig and handshaking with the VGA drawer.
//   Owns pause, game-over hold and restart.
//
// Optional feature macro: HISCORE_EN (adds the hi_score register and port).
//
// Ports
//   clk         system clock
//   resetn      asynchronous active-low reset
//   start       start key level; rising edge starts a game from IDLE
//   pause_sw    asynchronous pause switch (2-flop synchronised)
//   gameover    updater game-over flag, sampled in CHECK
//   draw_done   drawer pass complete (1-cycle pulse)
//   curr_score  current score from the updater
//   statesig    000 IDLE/WAIT/CHECK, 001 ERASE, 010 DRAW, 100 UPDATE, 111 OVER
//   draw_req    1-cycle pulse starting a drawer pass
//   erase       1 = drawer paints background colour
//   pause       synchronised pause, fed to the updater
//   frame_tick  1-cycle pulse once per FRAME_DIV clocks
//   score_clr   1-cycle pulse on game start
//   hi_score    best score seen (HISCORE_EN only)
module bounce_frame_sequencer #(
  parameter int unsigned FRAME_DIV     = 833333,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned GAMEOVER_HOLD = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pause_sw,
  input  logic        gameover,
  input  logic        draw_done,
  input  logic [15:0] curr_score,
  output logic [2:0]  statesig,
  output logic        draw_req,
  output logic        erase,
  output logic        pause,
  output logic        frame_tick,
  output logic        score_clr
`ifdef HISCORE_EN
  ,
  output logic [15:0] hi_score
`endif
);

  localparam int unsigned OVER_W = (GAMEOVER_HOLD < 2) ? 1 : $clog2(GAMEOVER_HOLD);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_DIV - 1);
  localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(GAMEOVER_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_CHECK,
    S_DRAW,
    S_WAIT,
    S_OVER
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [OVER_W-1:0]  over_cnt, over_cnt_n;
  logic               tick_pend, tick_pend_n;
  logic               pause_meta;
  logic               start_q;
  logic               start_rise;
  logic [2:0]         statesig_n;
  logic               draw_req_n, erase_n, score_clr_n;

  // Free-running frame divider, independent of the game state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
    end else if (frame_cnt == CNT_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign frame_tick = (frame_cnt == CNT_LAST);

  // pause_sw synchroniser; start_q resets high so a key held through reset
  // is not seen as a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pause_meta <= 1'b0;
      pause      <= 1'b0;
      start_q    <= 1'b1;
    end else begin
      pause_meta <= pause_sw;
      pause      <= pause_meta;
      start_q    <= start;
    end
  end

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      over_cnt  <= '0;
      tick_pend <= 1'b0;
      statesig  <= '0;
      draw_req  <= 1'b0;
      erase     <= 1'b0;
      score_clr <= 1'b0;
    end else begin
      state     <= next_state;
      over_cnt  <= over_cnt_n;
      tick_pend <= tick_pend_n;
      statesig  <= statesig_n;
      draw_req  <= draw_req_n;
      erase     <= erase_n;
      score_clr <= score_clr_n;
    end
  end

  // Outputs are registered from next_state so they line up exactly with the
  // state they describe.
  always_comb begin
    next_state  = state;
    over_cnt_n  = over_cnt;
    tick_pend_n = tick_pend;
    statesig_n  = 3'b000;
    draw_req_n  = 1'b0;
    erase_n     = 1'b0;
    score_clr_n = 1'b0;

    unique case (state)
      S_IDLE:   if (start_rise) next_state = S_ERASE;
      S_ERASE:  if (draw_done) next_state = S_UPDATE;
      S_UPDATE: next_state = S_CHECK;
      S_CHECK:  next_state = gameover ? S_OVER : S_DRAW;
      S_DRAW:   if (draw_done) next_state = S_WAIT;
      S_WAIT:   if (!pause && (frame_tick || tick_pend)) next_state = S_ERASE;
      S_OVER: begin
        if (frame_tick) begin
          if (over_cnt == OVER_LAST) begin
            over_cnt_n = '0;
            next_state = S_IDLE;
          end else begin
            over_cnt_n = over_cnt + OVER_W'(1);
          end
        end
      end
      default:  next_state = S_IDLE;
    endcase

    // A tick that WAIT cannot act on right now is remembered (one deep);
    // leaving WAIT consumes it.
    if (state == S_WAIT && next_state != S_WAIT) begin
      tick_pend_n = 1'b0;
    end else if (frame_tick && (state != S_WAIT || pause)) begin
      tick_pend_n = 1'b1;
    end

    score_clr_n = (state == S_IDLE) && (next_state == S_ERASE);

    case (next_state)
      S_ERASE: begin
        statesig_n = 3'b001;
        erase_n    = 1'b1;
        draw_req_n = (state != S_ERASE);
      end
      S_DRAW: begin
        statesig_n = 3'b010;
        draw_req_n = (state != S_DRAW);
      end
      S_UPDATE: statesig_n = 3'b100;
      S_OVER:   statesig_n = 3'b111;
      default:  statesig_n = 3'b000;
    endcase
  end

`ifdef HISCORE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_score <= '0;
    end else if (state == S_CHECK && curr_score > hi_score) begin
      hi_score <= curr_score;
    end
  end
`else
  // Score input is only consumed by the high-score tracker.
  logic unused_score;
  assign unused_score = ^curr_score;
`endif

endmodule

// File: tb/tb_bounce_frame_sequencer.sv
module tb_bounce_frame_sequencer;

  localparam int FD   = 4;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, pause_sw, gameover, draw_done;
  logic [15:0] curr_score;
  logic [2:0]  statesig;
  logic        draw_req, erase, pause, frame_tick, score_clr;
`ifdef HISCORE_EN
  logic [15:0] hi_score;
`endif

  always #5 clk = ~clk;

  bounce_frame_sequencer #(
    .FRAME_DIV(FD),
    .CNT_W(3),
    .GAMEOVER_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .pause_sw(pause_sw),
    .gameover(gameover),
    .draw_done(draw_done),
    .curr_score(curr_score),
    .statesig(statesig),
    .draw_req(draw_req),
    .erase(erase),
    .pause(pause),
    .frame_tick(frame_tick),
    .score_clr(score_clr)
`ifdef HISCORE_EN
    ,
    .hi_score(hi_score)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ERASE, M_UPDATE, M_CHECK, M_DRAW, M_WAIT, M_OVER} phase_t;

  phase_t      ph;
  bit          entered, pend, clr, p1, p2, prev_start;
  int          pos, over_ticks;
  logic [15:0] hi;

  int  n_tests = 0;
  int  n_fail  = 0;

  // drawer model
  bit  dd_active;
  int  dd_left;
  int  dd_delay = 3;
  bit  stray_en = 0;

  function automatic logic [2:0] sig_of(phase_t p);
    case (p)
      M_ERASE:  return 3'b001;
      M_DRAW:   return 3'b010;
      M_UPDATE: return 3'b100;
      M_OVER:   return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    ph = M_IDLE; entered = 0; pend = 0; clr = 0;
    p1 = 0; p2 = 0; prev_start = 1; pos = 0; over_ticks = 0; hi = '0;
  endtask

  task automatic model_advance();
    phase_t nxt;
    bit     tick_now, edge_seen;
    if (!resetn) begin
      model_reset();
      return;
    end
    tick_now  = (pos == FD - 1);
    edge_seen = start && !prev_start;
    nxt = ph;
    case (ph)
      M_IDLE:   if (edge_seen) nxt = M_ERASE;
      M_ERASE:  if (draw_done) nxt = M_UPDATE;
      M_UPDATE: nxt = M_CHECK;
      M_CHECK: begin
        if (curr_score > hi) hi = curr_score;
        nxt = gameover ? M_OVER : M_DRAW;
      end
      M_DRAW:   if (draw_done) nxt = M_WAIT;
      M_WAIT:   if (!p2 && (tick_now || pend)) nxt = M_ERASE;
      M_OVER: if (tick_now) begin
        over_ticks++;
        if (over_ticks == HOLD) begin
          over_ticks = 0;
          nxt = M_IDLE;
        end
      end
      default: nxt = M_IDLE;
    endcase
    if (ph == M_WAIT && nxt != M_WAIT) pend = 0;
    else if (tick_now && (ph != M_WAIT || p2)) pend = 1;
    clr        = (ph == M_IDLE && nxt == M_ERASE);
    entered    = (nxt != ph);
    ph         = nxt;
    prev_start = start;
    p2         = p1;
    p1         = pause_sw;
    pos        = (pos + 1) % FD;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    check("statesig",   32'(statesig),   32'(sig_of(ph)));
    check("draw_req",   32'(draw_req),   32'(entered && (ph == M_ERASE || ph == M_DRAW)));
    check("erase",      32'(erase),      32'(ph == M_ERASE));
    check("pause",      32'(pause),      32'(p2));
    check("frame_tick", 32'(frame_tick), 32'(pos == FD - 1));
    check("score_clr",  32'(score_clr),  32'(clr));
`ifdef HISCORE_EN
    check("hi_score",   32'(hi_score),   32'(hi));
`endif
  endtask

  task automatic drawer();
    bit dd = 0;
    if (dd_active) begin
      dd_left--;
      if (dd_left <= 0) begin
        dd = 1;
        dd_active = 0;
      end
    end
    if (entered && (ph == M_ERASE || ph == M_DRAW)) begin
      dd_active = 1;
      dd_left   = dd_delay;
    end
    if (!dd && stray_en && ph != M_ERASE && ph != M_DRAW && $urandom_range(0, 15) == 0) dd = 1;
    draw_done = dd;
  endtask

  // One clock: model consumes the inputs the DUT will sample, then outputs
  // are compared mid-cycle and the drawer response is driven.
  task automatic tick();
    model_advance();
    @(negedge clk);
    compare();
    drawer();
  endtask

  task automatic run_until(phase_t p, int limit);
    int n = 0;
    while (ph != p && n < limit) begin
      tick();
      n++;
    end
    check("reach_phase", 32'(n < limit || ph == p), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    dd_active = 0;
    draw_done = 1'b0;
    compare();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n, dr;
    logic [2:0] seq [12];
    logic [15:0] scores [3];
    logic [15:0] his [3];

    resetn = 0; start = 0; pause_sw = 0; gameover = 0; draw_done = 0; curr_score = '0;
    model_reset();
    dd_active = 0;
    @(negedge clk);
    compare();
    check("reset_statesig", 32'(statesig), 32'd0);
    resetn = 1;

    // 1: idle for 20 cycles
    cnt = 0; dr = 0;
    repeat (20) begin
      tick();
      if (frame_tick) cnt++;
      if (draw_req) dr++;
    end
    check("idle_ticks", 32'(cnt), 32'd5);
    check("idle_draw_req", 32'(dr), 32'd0);

    // 2: one full frame pass
    start = 1;
    tick();
    check("start_score_clr", 32'(score_clr), 32'd1);
    start = 0;
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b000,
            3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001};
    check("seq_0", 32'(statesig), 32'(seq[0]));
    for (int i = 1; i < 12; i++) begin
      tick();
      check("seq", 32'(statesig), 32'(seq[i]));
      if (i == 1) check("score_clr_once", 32'(score_clr), 32'd0);
    end

    // 3: pause asserted during DRAW
    run_until(M_DRAW, 40);
    pause_sw = 1;
    run_until(M_WAIT, 40);
    cnt = 0;
    repeat (16) begin
      tick();
      check("paused_hold", 32'(statesig), 32'd0);
      if (frame_tick) cnt++;
    end
    check("paused_ticks", 32'(cnt), 32'd4);
    pause_sw = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (statesig != 3'b001 && n < 10);
    check("pause_release_latency", 32'(n), 32'd3);

    // 5: drawer stall spanning three frame ticks
    run_until(M_CHECK, 40);
    dd_delay = 14;
    run_until(M_WAIT, 60);
    dd_delay = 3;
    tick();
    check("stall_immediate_erase", 32'(statesig), 32'd1);

`ifdef HISCORE_EN
    // 6: high score tracking
    scores = '{16'd5, 16'd3, 16'd9};
    his    = '{16'd5, 16'd5, 16'd9};
    for (int i = 0; i < 3; i++) begin
      run_until(M_CHECK, 60);
      curr_score = scores[i];
      tick();
      check("hi_score_step", 32'(hi_score), 32'(his[i]));
    end
    curr_score = '0;
`else
    scores = '{16'd0, 16'd0, 16'd0};
    his    = scores;
`endif

    // 4: game over, start held through OVER
    run_until(M_CHECK, 60);
    gameover = 1;
    start    = 1;
    tick();
    gameover = 0;
    check("over_statesig", 32'(statesig), 32'd7);
    cnt = 0; n = 0;
    while (statesig == 3'b111 && n < 30) begin
      if (frame_tick) cnt++;
      tick();
      n++;
    end
    check("over_ticks", 32'(cnt), 32'd2);
    check("over_to_idle", 32'(statesig), 32'd0);
    repeat (8) begin
      tick();
      check("held_start_ignored", 32'(statesig), 32'd0);
    end
    start = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    check("restart", 32'(statesig), 32'd1);

    // 6b: reset mid-ERASE
    tick();
    resetn = 0;
    #1;
    check("rst_statesig", 32'(statesig), 32'd0);
    check("rst_outputs", 32'({draw_req, erase, pause, frame_tick, score_clr}), 32'd0);
`ifdef HISCORE_EN
    check("rst_hi_score", 32'(hi_score), 32'd0);
`endif
    model_reset();
    dd_active = 0;
    draw_done = 0;
    tick();
    resetn = 1;

    // randomized play
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      gameover   = ($urandom_range(0, 4) == 0);
      curr_score = 16'($urandom);
      if ($urandom_range(0, 39) == 0) pause_sw = ~pause_sw;
      if ($urandom_range(0, 9) == 0) dd_delay = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(1, 8));
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
